// File: rtl/hps_spi_master_if.sv
// Word-side handshake of the HPS SPI master: 16-bit tx words in, rx words out.
// A tx word transfers on any sys_clk edge where tx_valid && tx_ready; tx_data/tx_last hold while tx_valid waits,
// and rx_valid is a one-cycle pulse with no backpressure (the consumer must take rx_data that cycle).
interface hps_spi_master_if;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;

  modport master (
    output tx_data, tx_last, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  tx_data, tx_last, tx_valid,
    output tx_ready, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/hps_spi_master.sv
// Master end of the 16-bit HPS SPI word link (mode: slave drives miso on spi_clk rise, samples mosi on fall).
// Optional HPS_SPI_MASTER_LOOPBACK_EN: sample spi_mosi instead of spi_miso for slave-less self-test.
module hps_spi_master #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int WORD_GAP = 8,
  parameter int CS_HOLD  = 6
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  hps_spi_master_if.slave        bus,
  output logic                   spi_clk,
  output logic                   spi_cs,
  output logic                   spi_mosi,
  input  logic                   spi_miso,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_GAP   = 3'd4,
    S_WAIT  = 3'd5,
    S_HOLD  = 3'd6,
    S_CSHI  = 3'd7
  } state_t;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP);
  localparam logic [15:0] GAP_LAST   = 16'(WORD_GAP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);

  state_t      state;
  logic [15:0] timer;
  logic [3:0]  bit_cnt;
  logic [14:0] tx_sr;
  logic [15:0] rx_sr;
  logic        last_word;
  logic        sample_bit;
  logic        accept;

`ifdef HPS_SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign sample_bit  = spi_mosi;
`else
  assign sample_bit  = spi_miso;
`endif

  assign bus.tx_ready = (state == S_IDLE) || (state == S_WAIT);
  assign bus.busy     = ~spi_cs;
  assign accept       = bus.tx_valid && bus.tx_ready;
  assign dbg_state    = state;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      last_word    <= 1'b0;
      spi_clk      <= 1'b0;
      spi_cs       <= 1'b1;
      spi_mosi     <= 1'b0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            tx_sr     <= bus.tx_data[14:0];
            last_word <= bus.tx_last;
            spi_cs    <= 1'b0;
            spi_mosi  <= bus.tx_data[15];
            timer     <= '0;
            state     <= S_SETUP;
          end
        end

        // Runs CS_SETUP+1 cycles so the first rising edge lands CS_SETUP+1 after accept.
        S_SETUP: begin
          if (timer == SETUP_LAST) begin
            timer   <= '0;
            spi_clk <= 1'b1;
            state   <= S_HIGH;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        S_HIGH: begin
          if (timer == DIV_LAST) begin
            timer   <= '0;
            spi_clk <= 1'b0;
            rx_sr   <= {rx_sr[14:0], sample_bit};
            bit_cnt <= bit_cnt + 4'd1;
            state   <= S_LOW;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        // mosi moves one cycle after the falling edge, clear of the slave's sample point.
        S_LOW: begin
          if (timer == 16'd0) begin
            spi_mosi <= tx_sr[14];
            tx_sr    <= {tx_sr[13:0], 1'b0};
          end
          if (timer == DIV_LAST) begin
            timer <= '0;
            if (bit_cnt == 4'd0) begin
              bus.rx_data  <= rx_sr;
              bus.rx_valid <= 1'b1;
              state        <= last_word ? S_HOLD : S_GAP;
            end else begin
              spi_clk <= 1'b1;
              state   <= S_HIGH;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end

        S_GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            state <= S_WAIT;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        // Frame stays open until the next word; it starts straight into HIGH.
        S_WAIT: begin
          if (accept) begin
            tx_sr     <= bus.tx_data[14:0];
            last_word <= bus.tx_last;
            spi_mosi  <= bus.tx_data[15];
            spi_clk   <= 1'b1;
            timer     <= '0;
            state     <= S_HIGH;
          end
        end

        S_HOLD: begin
          if (timer == HOLD_LAST) begin
            timer    <= '0;
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b0;
            state    <= S_CSHI;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        S_CSHI: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hps_spi_master.sv
// Bench for hps_spi_master: lane 0 runs CLK_DIV=2, lane 1 runs CLK_DIV=1, each with a negedge-sampling slave model.
`timescale 1ns/1ps
module tb_hps_spi_master;

  localparam int CS_SETUP = 2;
  localparam int WORD_GAP = 8;
  localparam int CS_HOLD  = 6;

  // clock / reset
  logic sys_clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic [15:0] tx_data_a  [2];
  logic        tx_last_a  [2];
  logic        tx_valid_a [2];
  logic        tx_ready_a [2];
  logic [15:0] rx_data_a  [2];
  logic        rx_valid_a [2];
  logic        busy_a     [2];
  logic        spi_clk_a  [2];
  logic        spi_cs_a   [2];
  logic        spi_mosi_a [2];
  logic [2:0]  dbg_a      [2];

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_rx_q   [2][$];
  logic [15:0] exp_mosi_q [2][$];
  int rxv_cnt  [2] = '{0, 0};
  int strb_cnt [2] = '{0, 0};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Words the slave model shifts back, in order of completed words per lane.
  function automatic logic [15:0] reply_word(input int g, input int n);
    if (g == 1) return (n == 0) ? 16'h1248 : 16'h8421;
    case (n)
      0:       return 16'h3C0F;
      1:       return 16'hF00D;
      2:       return 16'h0001;
      3:       return 16'h8001;
      4:       return 16'h5AA5;
      5:       return 16'h6969;
      default: return 16'hBEEF;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int DIV = (g == 0) ? 2 : 1;
    hps_spi_master_if bus();
    logic        dut_miso;
    logic        smiso = 1'b0;
    logic [3:0]  s_cnt = 4'd0;
    logic [15:0] s_rx = 16'd0;
    int          s_words = 0;

    assign bus.tx_data    = tx_data_a[g];
    assign bus.tx_last    = tx_last_a[g];
    assign bus.tx_valid   = tx_valid_a[g];
    assign tx_ready_a[g]  = bus.tx_ready;
    assign rx_data_a[g]   = bus.rx_data;
    assign rx_valid_a[g]  = bus.rx_valid;
    assign busy_a[g]      = bus.busy;
`ifdef HPS_SPI_MASTER_LOOPBACK_EN
    assign dut_miso = 1'b0;
`else
    assign dut_miso = smiso;
`endif

    hps_spi_master #(
      .CLK_DIV(DIV), .CS_SETUP(CS_SETUP), .WORD_GAP(WORD_GAP), .CS_HOLD(CS_HOLD)
    ) dut (
      .sys_clk   (sys_clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .spi_clk   (spi_clk_a[g]),
      .spi_cs    (spi_cs_a[g]),
      .spi_mosi  (spi_mosi_a[g]),
      .spi_miso  (dut_miso),
      .dbg_state (dbg_a[g])
    );

    // slave model: count restarts at frame start, miso on rise, mosi sampled on fall
    always @(negedge spi_cs_a[g]) s_cnt = 4'd0;

    always @(posedge spi_clk_a[g]) begin
      logic [15:0] rw;
      if (spi_cs_a[g] === 1'b0) begin
        rw = reply_word(g, s_words);
        smiso = rw[4'd15 - s_cnt];
      end
    end

    always @(negedge spi_clk_a[g]) begin
      if (spi_cs_a[g] === 1'b0) begin
        s_rx  = {s_rx[14:0], spi_mosi_a[g]};
        s_cnt = s_cnt + 4'd1;
        if (s_cnt == 4'd0) begin
          strb_cnt[g]++;
          s_words++;
          if (exp_mosi_q[g].size() == 0) check("mosi_unexpected_word", 32'd1, 32'd0);
          else check($sformatf("mosi_word_lane%0d", g), s_rx, exp_mosi_q[g].pop_front());
        end
      end
    end
  end

  // scoreboard monitor: every rx_valid pulse pops one expected word
  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rx_valid_a[i] === 1'b1) begin
        rxv_cnt[i]++;
        if (exp_rx_q[i].size() == 0) check($sformatf("rx_unexpected_lane%0d", i), 32'd1, 32'd0);
        else check($sformatf("rx_data_lane%0d", i), rx_data_a[i], exp_rx_q[i].pop_front());
      end
    end
  end

  // driver tasks
  task automatic send_word(input int g, input logic [15:0] d, input logic last,
                           input logic [15:0] exp_rx, input bit tracked);
    int n;
    @(negedge sys_clk);
    if (tracked) begin
      exp_rx_q[g].push_back(exp_rx);
      exp_mosi_q[g].push_back(d);
    end
    tx_data_a[g]  = d;
    tx_last_a[g]  = last;
    tx_valid_a[g] = 1'b1;
    n = 0;
    while (tx_ready_a[g] !== 1'b1 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 2000) check("accept_timeout", tx_ready_a[g], 32'd1);
    @(posedge sys_clk);
    #1;
    tx_valid_a[g] = 1'b0;
  endtask

  task automatic wait_cs_high(input int g);
    int n;
    n = 0;
    while (spi_cs_a[g] !== 1'b1 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 3000) check("frame_end_timeout", spi_cs_a[g], 32'd1);
  endtask

  task automatic measure_frame(input int g, input int div, output int cs_cyc, output int pulses,
                               output int first_rise, output int pmin, output int pmax,
                               output int long_runs, output int long_min);
    int n, last_rise, run;
    logic prev, cur;
    cs_cyc = 0; pulses = 0; first_rise = -1; pmin = 9999; pmax = 0;
    long_runs = 0; long_min = 9999; last_rise = 0; run = 0; prev = 1'b0;
    n = 0;
    while (spi_cs_a[g] !== 1'b0 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    check("frame_start", spi_cs_a[g], 32'd0);
    while (spi_cs_a[g] === 1'b0 && cs_cyc < 5000) begin
      cur = spi_clk_a[g];
      if (cur && !prev) begin
        if (pulses == 0) begin
          first_rise = cs_cyc;
        end else begin
          if (cs_cyc - last_rise < pmin) pmin = cs_cyc - last_rise;
          if (cs_cyc - last_rise > pmax) pmax = cs_cyc - last_rise;
          if (run > div) begin
            long_runs++;
            if (run < long_min) long_min = run;
          end
        end
        pulses++;
        last_rise = cs_cyc;
        run = 0;
      end else if (!cur) begin
        run++;
      end
      prev = cur;
      cs_cyc++;
      @(negedge sys_clk);
    end
    check("frame_closed", spi_cs_a[g], 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_cyc, pulses, first_rise, pmin, pmax, long_runs, long_min;
    int rx0, st0, n, falls, bad_clk, bad_cs, bad_rdy;
    logic prev, cur;

    for (int i = 0; i < 2; i++) begin
      tx_data_a[i] = 16'd0; tx_last_a[i] = 1'b0; tx_valid_a[i] = 1'b0;
    end
    #2 reset_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_spi_cs",   spi_cs_a[0],   32'd1);
    check("reset_spi_clk",  spi_clk_a[0],  32'd0);
    check("reset_spi_mosi", spi_mosi_a[0], 32'd0);
    check("reset_rx_valid", rx_valid_a[0], 32'd0);
    check("reset_rx_data",  rx_data_a[0],  32'd0);
    check("reset_busy",     busy_a[0],     32'd0);
    check("reset_state",    dbg_a[0],      32'd0);
    check("reset_cs_lane1", spi_cs_a[1],   32'd1);
    reset_n = 1'b1;
    repeat (3) @(negedge sys_clk);

`ifdef HPS_SPI_MASTER_LOOPBACK_EN
    rx0 = rxv_cnt[0];
    send_word(0, 16'hC3A5, 1'b1, 16'hC3A5, 1'b1);
    wait_cs_high(0);
    check("loopback_rx_count", rxv_cnt[0] - rx0, 32'd1);
`else
    // single-word frame
    rx0 = rxv_cnt[0]; st0 = strb_cnt[0];
    fork
      send_word(0, 16'hA55A, 1'b1, 16'h3C0F, 1'b1);
      measure_frame(0, 2, cs_cyc, pulses, first_rise, pmin, pmax, long_runs, long_min);
    join
    check("t1_pulses",     pulses,     32'd16);
    check("t1_period_min", pmin,       32'd4);
    check("t1_period_max", pmax,       32'd4);
    check("t1_first_rise", first_rise, 32'd3);
    check("t1_cs_low",     cs_cyc,     32'd73);
    check("t1_rx_pulses",  rxv_cnt[0] - rx0,  32'd1);
    check("t1_strobes",    strb_cnt[0] - st0, 32'd1);
    repeat (4) @(negedge sys_clk);

    // three-word frame
    rx0 = rxv_cnt[0]; st0 = strb_cnt[0];
    fork
      begin
        send_word(0, 16'h0001, 1'b0, 16'hF00D, 1'b1);
        send_word(0, 16'h8000, 1'b0, 16'h0001, 1'b1);
        send_word(0, 16'hFFFF, 1'b1, 16'h8001, 1'b1);
      end
      measure_frame(0, 2, cs_cyc, pulses, first_rise, pmin, pmax, long_runs, long_min);
    join
    check("t2_pulses",     pulses,    32'd48);
    check("t2_gap_count",  long_runs, 32'd2);
    check("t2_gap_min_ge8", (long_min >= WORD_GAP), 32'd1);
    check("t2_rx_pulses",  rxv_cnt[0] - rx0,  32'd3);
    check("t2_strobes",    strb_cnt[0] - st0, 32'd3);
    repeat (4) @(negedge sys_clk);

    // stall in WAIT
    rx0 = rxv_cnt[0];
    send_word(0, 16'h1357, 1'b0, 16'h5AA5, 1'b1);
    n = 0;
    while (tx_ready_a[0] !== 1'b1 && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    check("t3_enter_wait", tx_ready_a[0], 32'd1);
    bad_clk = 0; bad_cs = 0; bad_rdy = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (spi_clk_a[0] !== 1'b0) bad_clk++;
      if (spi_cs_a[0] !== 1'b0) bad_cs++;
      if (tx_ready_a[0] !== 1'b1) bad_rdy++;
    end
    check("t3_stall_clk_low",  bad_clk, 32'd0);
    check("t3_stall_cs_low",   bad_cs,  32'd0);
    check("t3_stall_ready",    bad_rdy, 32'd0);
    send_word(0, 16'h2468, 1'b1, 16'h6969, 1'b1);
    check("t3_no_setup_rise", spi_clk_a[0], 32'd1);
    wait_cs_high(0);
    check("t3_rx_pulses", rxv_cnt[0] - rx0, 32'd2);
    repeat (4) @(negedge sys_clk);

    // reset mid-word
    rx0 = rxv_cnt[0];
    send_word(0, 16'h7777, 1'b1, 16'h0000, 1'b0);
    falls = 0; n = 0; prev = spi_clk_a[0];
    while (falls < 7 && n < 1000) begin
      @(negedge sys_clk);
      cur = spi_clk_a[0];
      if (prev && !cur) falls++;
      prev = cur;
      n++;
    end
    n = 0;
    while (spi_clk_a[0] !== 1'b1 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check("t4_clk_high_before_abort", spi_clk_a[0], 32'd1);
    reset_n = 1'b0;
    #1;
    check("t4_abort_cs",   spi_cs_a[0],   32'd1);
    check("t4_abort_clk",  spi_clk_a[0],  32'd0);
    check("t4_abort_busy", busy_a[0],     32'd0);
    check("t4_abort_mosi", spi_mosi_a[0], 32'd0);
    repeat (3) @(negedge sys_clk);
    reset_n = 1'b1;
    check("t4_no_rx_on_abort", rxv_cnt[0] - rx0, 32'd0);
    repeat (2) @(negedge sys_clk);
    send_word(0, 16'h1234, 1'b1, 16'hBEEF, 1'b1);
    wait_cs_high(0);
    check("t4_rx_after_reset", rxv_cnt[0] - rx0, 32'd1);
    repeat (4) @(negedge sys_clk);

    // CLK_DIV=1 back-to-back on lane 1
    rx0 = rxv_cnt[1]; st0 = strb_cnt[1];
    fork
      begin
        send_word(1, 16'hFFFF, 1'b0, 16'h1248, 1'b1);
        send_word(1, 16'h0000, 1'b1, 16'h8421, 1'b1);
      end
      measure_frame(1, 1, cs_cyc, pulses, first_rise, pmin, pmax, long_runs, long_min);
    join
    check("t5_pulses",      pulses,     32'd32);
    check("t5_period_min",  pmin,       32'd2);
    check("t5_first_rise",  first_rise, 32'd3);
    check("t5_gap_count",   long_runs,  32'd1);
    check("t5_gap_min_ge8", (long_min >= WORD_GAP), 32'd1);
    check("t5_rx_pulses",   rxv_cnt[1] - rx0,  32'd2);
    check("t5_strobes",     strb_cnt[1] - st0, 32'd2);
`endif

    repeat (20) @(negedge sys_clk);
    check("left_rx_lane0",   exp_rx_q[0].size(),   32'd0);
    check("left_rx_lane1",   exp_rx_q[1].size(),   32'd0);
    check("left_mosi_lane0", exp_mosi_q[0].size(), 32'd0);
    check("left_mosi_lane1", exp_mosi_q[1].size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
